nibble_add_sequencer: RTL and testbench
=======================================

NIBBLE_ADD_SEQUENCER -- requirements
Module: nibble_add_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width in 4-bit slices (allowed range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port a, input, 4*NIBBLES bits: operand A, captured on an accepted start.
REQ-006 SHALL have port b, input, 4*NIBBLES bits: operand B, captured on an accepted start.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port sum, output, 4*NIBBLES bits: result, held until the next accepted start.
REQ-011 SHALL have port cout, output, 1 bit: carry out of the MSB nibble.
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow, i.e. carry-into-MSB XOR carry-out-of-MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; IDLE goes to RUN on start=1; RUN goes to DONE after NIBBLES slice cycles; DONE goes to IDLE unconditionally.
REQ-014 SHALL, on an accepted start, register a, b and cin, clear the nibble index to 0, and clear sum.
REQ-015 SHALL, in RUN, add exactly one nibble per cycle with a single 4-bit adder slice, LSB nibble first: slice inputs a[idx], b[idx] and the running carry; the slice sum is written to sum[idx]; the slice carry is registered for the next cycle.
REQ-016 SHALL set the running carry for nibble 0 to the captured cin.
REQ-017 SHALL assert done exactly NIBBLES+1 cycles after the clk edge that accepts start, for exactly one cycle, while in DONE.
REQ-018 SHALL have cout, ovf and sum stable and valid from the cycle done asserts until the next accepted start.
REQ-019 SHALL ignore start while busy=1: no re-capture, no restart, no error.
REQ-020 SHALL accept start=1 held through DONE on the first IDLE cycle, giving a back-to-back operation every NIBBLES+2 cycles.
REQ-021 SHALL make the nibble index wrap only through IDLE; the index never exceeds NIBBLES-1 in RUN.
REQ-022 SHALL treat arithmetic as modulo 2^(4*NIBBLES), with the carry reported only on cout.

Reset
REQ-023 SHALL, on rst=1, force the state to IDLE immediately (asynchronously) and set busy=0, done=0, sum=0, cout=0, ovf=0, the index to 0, and the carry to 0.
REQ-024 SHALL, on rst asserted mid-RUN, abort the operation; no done is produced for it, and start is honoured on the first clk edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro NIBBLE_ADD_SUB_EN defined, add input port sub (1 bit, captured on start); when sub=1, the block computes a - b by feeding ~b[idx] to the slice and forcing the nibble-0 carry to 1, ignoring cin; cout=1 means no borrow.
REQ-026 SHALL, with NIBBLE_ADD_SUB_EN undefined, have no sub port and perform addition only.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, RUN, DONE) and constant NIBBLE_W=4 in shared package nibble_add_pkg.
REQ-028 SHALL instantiate one combinational sub-module, cla4_slice (4-bit carry-lookahead slice with inputs a, b, ci and outputs s, co); the sequencer holds all state.

Verification
REQ-029 SHALL cover: NIBBLES=4, a=16'hFFFF, b=16'h0001, cin=0 -> done on the 5th cycle after start, sum=16'h0000, cout=1, ovf=0.
REQ-030 SHALL cover: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
REQ-031 SHALL cover: a=16'h1234, b=16'h0FFF, cin=1 -> sum=16'h2234, cout=0; a second start pulsed during RUN is ignored and sum is unchanged.
REQ-032 SHALL cover: rst pulsed in the 2nd RUN cycle -> busy=0 and sum=0 immediately, no done pulse; a subsequent op with a=16'h0009, b=16'h0001, cin=1 gives sum=16'h000B.
REQ-033 SHALL cover: start held high for 20 cycles -> done pulses every 6 cycles and busy drops for exactly one cycle between operations.
REQ-034 SHALL cover, with NIBBLE_ADD_SUB_EN defined: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index register width; a single-nibble build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W:0]   c;

    // Propagate/generate terms and flattened lookahead carries
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[NIBBLE_W-1:0];
        co   = c[4];
    end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Nibble-serial adder: one 4-bit CLA slice reused LSB nibble first.
// Optional subtract mode (port sub) is enabled by defining NIBBLE_ADD_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start=1
// RUN   | one nibble added per cycle, index 0..NIBBLES-1
// DONE  | result valid, done pulses for this single cycle
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                         sub,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout,
    output logic                         ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                co_nib;
    logic                c_msb;

    // Route the active nibble of the captured operands to the slice
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (co_nib)
    );

    // Carry into the top bit recovered from the slice sum: s = a ^ b ^ c
    assign c_msb = s_nib[NIBBLE_W-1] ^ a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1];

    // Next-state and datapath update; subtract is stored as inverted B
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
`ifdef NIBBLE_ADD_SUB_EN
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = s_nib;
                    end
                end
                carry_d = co_nib;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                    cout_d  = co_nib;
                    ovf_d   = co_nib ^ c_msb;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer (NIBBLES=4).
// Subtract cases are included when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_add_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NIBBLE_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    nibble_add_sequencer #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef NIBBLE_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation from start to the cycle after done, checked against a
    // whole-word arithmetic model.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub, input logic poke);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         exp_ovf;
        int           lat;
        bb      = tsub ? ~tb_v : tb_v;
        full    = {1'b0, ta} + {1'b0, bb} + (tsub ? 17'd1 : {16'd0, tcin});
        exp_ovf = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);

        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tcin;
`ifdef NIBBLE_ADD_SUB_EN
        sub   = tsub;
`endif
        @(negedge clk);
        lat   = 1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = ~tcin;
        chk("busy_run", 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 2) begin
                start = 1'b1;
                a     = 16'($urandom);
                b     = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", 32'(lat), 32'd5);
        chk("sum", 32'(sum), 32'(full[W-1:0]));
        chk("cout", 32'(cout), 32'(full[W]));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("sum_hold", 32'(sum), 32'(full[W-1:0]));
    endtask

    initial begin
        logic seen_done;
        logic exp_done;
        logic exp_busy;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Directed corner cases
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1;
        a     = 16'h4321;
        b     = 16'h1111;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        run_op(16'h0009, 16'h0001, 1'b1, 1'b0, 1'b0);

        // Start held for 20 cycles: back-to-back operations every 6 cycles
        @(negedge clk);
        start = 1'b1;
        a     = 16'h0102;
        b     = 16'h0304;
        cin   = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
        sub   = 1'b0;
`endif
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_done = (k >= 5) && ((k - 5) % 6 == 0);
            exp_busy = (k % 6 != 0);
            chk($sformatf("b2b_done_%0d", k), 32'(done), 32'(exp_done));
            chk($sformatf("b2b_busy_%0d", k), 32'(busy), 32'(exp_busy));
            if (exp_done) chk("b2b_sum", 32'(sum), 32'h0406);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_drain_busy", 32'(busy), 32'd0);

`ifdef NIBBLE_ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
`endif

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            logic rsub;
`ifdef NIBBLE_ADD_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom), rsub, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
